// File: rtl/serial_word_receiver.sv
// serial_word_receiver: receive side of the single-wire serial word link.
// Re-synchronizes the data/enable lines, reassembles a 32-bit word sent MSB
// first, checks frame length and trailer bit, and hands good words to a
// consumer over a valid/ack handshake.
module serial_word_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ser_data,
   input  logic        ser_en,
   output logic [31:0] word,
   output logic        word_valid,
   input  logic        word_ack,
   output logic        busy,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        overrun,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, SHIFT, TRAIL} state_t;

   // Synchronized samples. rdy_s marks that the synchronizer has refilled
   // since reset, so its reset zeros are never mistaken for a low enable
   // (which would let a frame already in flight be picked up mid-way).
   logic en_s, din_s, rdy_s;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign en_s  = ser_en;
         assign din_s = ser_data;
         assign rdy_s = 1'b1;
      end else begin : g_sync
         logic [2:0] stage [SYNC_STAGES];

         // Shift {ready, enable, data} through the synchronizer chain.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= 3'b000;
            end else begin
               stage[0] <= {1'b1, ser_en, ser_data};
               for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            end
         end

         assign {rdy_s, en_s, din_s} = stage[SYNC_STAGES-1];
      end
   endgenerate

   state_t      state, state_next;
   logic [5:0]  hc, hc_next;
   logic [31:0] sr, sr_next;
   logic        trailer, trailer_next;
   logic        good, bad;
   logic [1:0]  bad_code;

   // Frame state, cycle counter, shift register and captured trailer bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= WAIT_LOW;
         hc      <= 6'd0;
         sr      <= 32'd0;
         trailer <= 1'b0;
      end else begin
         state   <= state_next;
         hc      <= hc_next;
         sr      <= sr_next;
         trailer <= trailer_next;
      end
   end

   // Next-state logic; frame verdict is decided on the first low en_s.
   always_comb begin
      state_next   = state;
      hc_next      = hc;
      sr_next      = sr;
      trailer_next = trailer;
      good         = 1'b0;
      bad          = 1'b0;
      bad_code     = 2'b00;
      case (state)
         WAIT_LOW: begin
            if (rdy_s && !en_s) state_next = IDLE;
         end
         IDLE: begin
            if (en_s) begin
               state_next = SHIFT;
               hc_next    = 6'd1;
            end
         end
         SHIFT: begin
            if (!en_s) begin
               bad        = 1'b1;
               bad_code   = 2'b01;
               state_next = IDLE;
            end else begin
               sr_next = {sr[30:0], din_s};
               hc_next = hc + 6'd1;
               if (hc == 6'd32) state_next = TRAIL;
            end
         end
         TRAIL: begin
            if (!en_s) begin
               state_next = IDLE;
               if (hc > 6'd34) begin
                  bad      = 1'b1;
                  bad_code = 2'b10;
               end else if (hc < 6'd34) begin
                  // Enable dropped right after the last data bit: no trailer.
                  bad      = 1'b1;
                  bad_code = 2'b01;
               end else if (trailer) begin
                  bad      = 1'b1;
                  bad_code = 2'b11;
               end else begin
                  good = 1'b1;
               end
            end else begin
               if (hc == 6'd33) trailer_next = din_s;
               if (hc != 6'd63) hc_next = hc + 6'd1;
            end
         end
         default: state_next = WAIT_LOW;
      endcase
   end

   assign busy = (state == SHIFT) || (state == TRAIL);

   // Consumer side: word hand-off, handshake, error/overrun pulses, count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word        <= 32'd0;
         word_valid  <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= 2'b00;
         overrun     <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         frame_err <= bad;
         overrun   <= good && word_valid && !word_ack;
         if (bad) err_code <= bad_code;
         if (good) begin
            word        <= sr;
            word_valid  <= 1'b1;
            frame_count <= frame_count + 16'd1;
         end else if (word_ack) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed testbench for serial_word_receiver (SYNC_STAGES = 2).
module tb_serial_word_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic        ser_data, ser_en, word_ack;
   logic [31:0] word;
   logic        word_valid, busy, frame_err, overrun;
   logic [1:0]  err_code;
   logic [15:0] frame_count;

   int total = 0;
   int bad = 0;
   int ovr_seen = 0;
   int err_seen = 0;
   logic [31:0] acked_word;

   serial_word_receiver #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .ser_data(ser_data), .ser_en(ser_en),
      .word(word), .word_valid(word_valid), .word_ack(word_ack),
      .busy(busy), .frame_err(frame_err), .err_code(err_code),
      .overrun(overrun), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (overrun === 1'b1) ovr_seen++;
      if (frame_err === 1'b1) err_seen++;
   end

   // Send one frame: `high` cycles of enable, then one low cycle.
   // ack_k >= 0 asserts word_ack for the one cycle at that k.
   task automatic send_frame(input logic [31:0] data, input int high,
                             input logic trl, input int ack_k);
      for (int k = 0; k < high; k++) begin
         @(negedge clk);
         ser_en = 1'b1;
         if (k >= 1 && k <= 32) ser_data = data[32-k];
         else if (k == 33)     ser_data = trl;
         else                  ser_data = 1'b0;
         if (k == ack_k) acked_word = word;
         word_ack = (k == ack_k);
      end
      @(negedge clk);
      ser_en   = 1'b0;
      ser_data = 1'b0;
      word_ack = 1'b0;
   endtask

   task automatic do_ack();
      @(negedge clk);
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ser_en = 1'b0; ser_data = 1'b0; word_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({word, word_valid, busy, frame_err, err_code, overrun, frame_count} !== 54'd0) begin
         bad++;
         $display("FAIL reset_state: word=%h valid=%b busy=%b err=%b code=%b ovr=%b cnt=%0d, required all zero",
                  word, word_valid, busy, frame_err, err_code, overrun, frame_count);
      end
   endtask

   task automatic test_good_frame();
      logic busy_mid;
      send_frame(32'hA5C3_0F81, 34, 1'b0, -1);
      repeat (2) @(negedge clk);
      busy_mid = busy;
      total++;
      if (word_valid !== 1'b0) begin
         bad++; $display("FAIL good_early_valid: valid=%b required 0", word_valid);
      end
      total++;
      if (busy_mid !== 1'b1) begin
         bad++; $display("FAIL good_busy: busy=%b required 1", busy_mid);
      end
      @(negedge clk);
      total++;
      if (word_valid !== 1'b1 || word !== 32'hA5C3_0F81 || busy !== 1'b0) begin
         bad++;
         $display("FAIL good_word: valid=%b word=%h busy=%b required 1 a5c30f81 0", word_valid, word, busy);
      end
      total++;
      if (frame_count !== 16'd1 || frame_err !== 1'b0 || err_seen != 0) begin
         bad++;
         $display("FAIL good_count: cnt=%0d err=%b errs=%0d required 1 0 0", frame_count, frame_err, err_seen);
      end
      do_ack();
      total++;
      if (word_valid !== 1'b0) begin
         bad++; $display("FAIL ack_clear: valid=%b required 0", word_valid);
      end
   endtask

   task automatic test_back_to_back();
      int ovr0;
      ovr0 = ovr_seen;
      send_frame(32'h0000_0001, 34, 1'b0, -1);
      send_frame(32'hFFFF_FFFF, 34, 1'b0, 10);
      repeat (3) @(negedge clk);
      total++;
      if (acked_word !== 32'h0000_0001) begin
         bad++; $display("FAIL b2b_first: word=%h required 00000001", acked_word);
      end
      total++;
      if (word !== 32'hFFFF_FFFF || word_valid !== 1'b1 || frame_count !== 16'd3) begin
         bad++;
         $display("FAIL b2b_second: word=%h valid=%b cnt=%0d required ffffffff 1 3", word, word_valid, frame_count);
      end
      total++;
      if (ovr_seen != ovr0) begin
         bad++; $display("FAIL b2b_overrun: pulses=%0d required 0", ovr_seen - ovr0);
      end
   endtask

   task automatic test_overrun();
      int ovr0;
      do_ack();
      ovr0 = ovr_seen;
      send_frame(32'h0000_0001, 34, 1'b0, -1);
      send_frame(32'hFFFF_FFFF, 34, 1'b0, -1);
      repeat (3) @(negedge clk);
      total++;
      if (overrun !== 1'b1) begin
         bad++; $display("FAIL overrun_pulse: overrun=%b required 1", overrun);
      end
      @(negedge clk);
      total++;
      if (ovr_seen - ovr0 != 1 || word !== 32'hFFFF_FFFF || word_valid !== 1'b1 || frame_count !== 16'd5) begin
         bad++;
         $display("FAIL overrun_state: pulses=%0d word=%h valid=%b cnt=%0d required 1 ffffffff 1 5",
                  ovr_seen - ovr0, word, word_valid, frame_count);
      end
   endtask

   task automatic test_errors();
      int          len [3]  = '{20, 36, 34};
      logic        trl [3]  = '{1'b0, 1'b0, 1'b1};
      logic [1:0]  code [3] = '{2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 3; i++) begin
         send_frame(32'hDEAD_BEEF, len[i], trl[i], -1);
         repeat (3) @(negedge clk);
         total++;
         if (frame_err !== 1'b1 || err_code !== code[i]) begin
            bad++;
            $display("FAIL err_case%0d: err=%b code=%b required 1 %b", i, frame_err, err_code, code[i]);
         end
         @(negedge clk);
         total++;
         if (frame_err !== 1'b0 || err_code !== code[i] || word !== 32'hFFFF_FFFF ||
             word_valid !== 1'b1 || frame_count !== 16'd5) begin
            bad++;
            $display("FAIL err_hold%0d: err=%b code=%b word=%h valid=%b cnt=%0d required 0 %b ffffffff 1 5",
                     i, frame_err, err_code, word, word_valid, frame_count, code[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int errs0;
      errs0 = err_seen;
      for (int k = 0; k < 34; k++) begin
         @(negedge clk);
         ser_en   = 1'b1;
         ser_data = k[0];
         reset    = (k == 10);
         if (k == 10) begin
            #1;
            total++;
            if (word_valid !== 1'b0 || word !== 32'd0 || frame_count !== 16'd0 || busy !== 1'b0) begin
               bad++;
               $display("FAIL async_reset: valid=%b word=%h cnt=%0d busy=%b required 0 0 0 0",
                        word_valid, word, frame_count, busy);
            end
         end
      end
      @(negedge clk);
      ser_en = 1'b0; ser_data = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (word_valid !== 1'b0 || err_seen != errs0 || err_code !== 2'b00 || frame_count !== 16'd0) begin
         bad++;
         $display("FAIL drop_after_reset: valid=%b errs=%0d code=%b cnt=%0d required 0 0 00 0",
                  word_valid, err_seen - errs0, err_code, frame_count);
      end
      send_frame(32'h1234_5678, 34, 1'b0, -1);
      repeat (3) @(negedge clk);
      total++;
      if (word !== 32'h1234_5678 || word_valid !== 1'b1 || frame_count !== 16'd1) begin
         bad++;
         $display("FAIL post_reset_frame: word=%h valid=%b cnt=%0d required 12345678 1 1", word, word_valid, frame_count);
      end
   endtask

   task automatic test_ack_same_edge();
      send_frame(32'hCAFE_F00D, 34, 1'b0, -1);
      repeat (2) @(negedge clk);
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
      total++;
      if (word_valid !== 1'b1 || word !== 32'hCAFE_F00D || overrun !== 1'b0 || frame_count !== 16'd2) begin
         bad++;
         $display("FAIL ack_same_edge: valid=%b word=%h ovr=%b cnt=%0d required 1 cafef00d 0 2",
                  word_valid, word, overrun, frame_count);
      end
   endtask

   task automatic test_wrap();
      do_ack();
      @(negedge clk);
      force dut.frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count;
      @(negedge clk);
      total++;
      if (frame_count !== 16'hFFFF) begin
         bad++; $display("FAIL wrap_preload: cnt=%0d required 65535", frame_count);
      end
      send_frame(32'h0BAD_CAFE, 34, 1'b0, -1);
      repeat (3) @(negedge clk);
      total++;
      if (frame_count !== 16'd0 || word !== 32'h0BAD_CAFE) begin
         bad++; $display("FAIL wrap: cnt=%0d word=%h required 0 0badcafe", frame_count, word);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_back_to_back();
      test_overrun();
      test_errors();
      test_reset_mid_frame();
      test_ack_same_edge();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
